// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and the op field width.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OpAnd   = 4'd0,
        OpOr    = 4'd1,
        OpAdd   = 4'd2,
        OpZero  = 4'd3,
        OpAddNb = 4'd4,
        OpOrNb  = 4'd5,
        OpSub   = 4'd6,
        OpSlt   = 4'd7,
        OpMultu = 4'd8,
        OpMult  = 4'd9,
        OpDivu  = 4'd10,
        OpDiv   = 4'd11,
        OpMfhi  = 4'd12,
        OpMflo  = 4'd13,
        OpRsv14 = 4'd14,
        OpRsv15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } state_e;

    function automatic logic op_is_mul(alu_op_e op);
        return (op == OpMultu) || (op == OpMult);
    endfunction

    function automatic logic op_is_div(alu_op_e op);
        return (op == OpDivu) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the execute-stage controller (master) and seq_alu (slave).
interface seq_alu_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic                start;
    logic [ALU_OP_W-1:0] f;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [WIDTH-1:0]    y;
    logic                zero;
    logic [WIDTH-1:0]    hi;
    logic [WIDTH-1:0]    lo;
    logic                busy;
    logic                done;

    modport master (
        output start, f, a, b,
        input  y, zero, hi, lo, busy, done
    );

    modport slave (
        input  start, f, a, b,
        output y, zero, hi, lo, busy, done
    );

endinterface

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider with sign fix-up and the HI/LO registers.
// The divider datapath is only built when SEQ_ALU_DIV_EN is defined.
module seq_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic             wr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic                 run_q, run_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mb_q, mb_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   mul_res;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign fin = run_q && (cnt_q == CntLast);

    // acc holds {upper, multiplier} while multiplying; low bit selects the add, then shift right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mb_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign mul_res  = neg_q ? -acc_q : acc_q;

`ifdef SEQ_ALU_DIV_EN
    logic                 div_q, div_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH-1:0]     rem_sub;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo, rem;

    // acc holds {remainder, dividend/quotient}; quotient bits shift in from the right.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = rem_sh >= {1'b0, mb_q};
    assign rem_sub  = rem_sh[WIDTH-1:0] - mb_q;
    assign div_next = {(div_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    assign quo      = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];
    assign acc_step = div_q ? div_next : mul_next;

    always_comb begin
        fix_hi = mul_res[2*WIDTH-1:WIDTH];
        fix_lo = mul_res[WIDTH-1:0];
        if (div_q) begin
            fix_lo = dz_q ? '1  : (neg_q  ? -quo : quo);
            fix_hi = dz_q ? a_q : (rneg_q ? -rem : rem);
        end
    end
`else
    logic unused_is_div;
    assign unused_is_div = is_div;
    assign acc_step      = mul_next;
    assign fix_hi        = mul_res[2*WIDTH-1:WIDTH];
    assign fix_lo        = mul_res[WIDTH-1:0];
`endif

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        mb_d  = mb_q;
        neg_d = neg_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
`ifdef SEQ_ALU_DIV_EN
        div_d  = div_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        a_d    = a_q;
`endif
        if (go) begin
            run_d = 1'b1;
            cnt_d = '0;
            acc_d = {{WIDTH{1'b0}}, a_mag};
            mb_d  = b_mag;
            neg_d = a_neg ^ b_neg;
`ifdef SEQ_ALU_DIV_EN
            div_d  = is_div;
            rneg_d = a_neg;
            dz_d   = (b == '0);
            a_d    = a;
`endif
        end else if (run_q) begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (fin) begin
                run_d = 1'b0;
            end
        end
        if (wr) begin
            hi_d = fix_hi;
            lo_d = fix_lo;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            mb_q  <= '0;
            neg_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            a_q    <= '0;
`endif
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            mb_q  <= mb_d;
            neg_q <= neg_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= div_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
            a_q    <= a_d;
`endif
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: registered single-cycle ops plus iterative mul/div into HI/LO.
// Define SEQ_ALU_DIV_EN to build DIV/DIVU; otherwise they complete as reserved ops.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic clk,
    input  logic reset_n,
    seq_alu_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    alu_op_e          op;
    logic             is_mul, is_div;
    logic             go, fin, fix;
    logic             slt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] md_hi, md_lo;

    assign op     = alu_op_e'(bus.f);
    assign is_mul = op_is_mul(op);
`ifdef SEQ_ALU_DIV_EN
    assign is_div = op_is_div(op);
`else
    assign is_div = 1'b0;
`endif
    assign go  = (state_q == StIdle) && bus.start && (is_mul || is_div);
    assign fix = (state_q == StFix);

    // Direct signed compare stays correct when a - b overflows.
    assign slt = $signed(bus.a) < $signed(bus.b);

    always_comb begin
        alu_res = '0;
        case (op)
            OpAnd:   alu_res = bus.a & bus.b;
            OpOr:    alu_res = bus.a | bus.b;
            OpAdd:   alu_res = bus.a + bus.b;
            OpAddNb: alu_res = bus.a + ~bus.b;
            OpOrNb:  alu_res = bus.a | ~bus.b;
            OpSub:   alu_res = bus.a - bus.b;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, slt};
            OpMfhi:  alu_res = md_hi;
            OpMflo:  alu_res = md_lo;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (is_mul) begin
                        state_d = StMul;
                    end else if (is_div) begin
                        state_d = StDiv;
                    end else begin
                        y_d    = alu_res;
                        zero_d = (alu_res == '0);
                        done_d = 1'b1;
                    end
                end
            end
            StMul, StDiv: begin
                if (fin) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            y_q     <= '0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (go),
        .is_div   (bus.f[1]),
        .is_signed(bus.f[0]),
        .wr       (fix),
        .a        (bus.a),
        .b        (bus.b),
        .fin      (fin),
        .hi       (md_hi),
        .lo       (md_lo)
    );

    assign bus.y    = y_q;
    assign bus.zero = zero_q;
    assign bus.hi   = md_hi;
    assign bus.lo   = md_lo;
    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): vector table, corner sequences, random vs model.
// Divider checks follow the SEQ_ALU_DIV_EN build option.
module tb_seq_alu;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: expected y/zero and architectural HI/LO.
    logic [W-1:0] ym, him, lom;
    logic         zm, multim;

    typedef struct {
        logic [3:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         z;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb;
        logic [63:0]  p;
        multim = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            4'd0:  ym = a & b;
            4'd1:  ym = a | b;
            4'd2:  ym = a + b;
            4'd3:  ym = '0;
            4'd4:  ym = a + ~b;
            4'd5:  ym = a | ~b;
            4'd6:  ym = a - b;
            4'd7:  ym = (sa < sb) ? 32'd1 : 32'd0;
            4'd8: begin
                p = {32'd0, a} * {32'd0, b};
                {him, lom} = p;
                multim = 1'b1;
            end
            4'd9: begin
                p = sa * sb;
                {him, lom} = p;
                multim = 1'b1;
            end
`ifdef SEQ_ALU_DIV_EN
            4'd10: begin
                multim = 1'b1;
                if (b == 0) begin lom = '1; him = a; end
                else begin lom = a / b; him = a % b; end
            end
            4'd11: begin
                multim = 1'b1;
                if (b == 0) begin lom = '1; him = a; end
                else begin p = sa / sb; lom = p[W-1:0]; p = sa % sb; him = p[W-1:0]; end
            end
`endif
            4'd12: ym = him;
            4'd13: ym = lom;
            default: ym = '0;
        endcase
        if (!multim) zm = (ym == 0);
    endtask

    // Issue one request; lat = edges from accept to the edge that raised done.
    task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.f = f;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.f = 4'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
        lat = 0;
        bc = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int lat, bc;
        model_op(f, a, b);
        issue(f, a, b, lat, bc);
        chk({name, " done"}, bus.done, 1'b1);
        chk({name, " latency"}, lat, multim ? W + 1 : 0);
        chk({name, " busy cycles"}, bc, multim ? W + 1 : 0);
        chk({name, " y"}, bus.y, ym);
        chk({name, " zero"}, bus.zero, zm);
        chk({name, " hi"}, bus.hi, him);
        chk({name, " lo"}, bus.lo, lom);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, " y"}, bus.y, 0);
        chk({name, " zero"}, bus.zero, 1);
        chk({name, " hi"}, bus.hi, 0);
        chk({name, " lo"}, bus.lo, 0);
        chk({name, " busy"}, bus.busy, 0);
        chk({name, " done"}, bus.done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, bc, dones;
        logic [3:0] rf;
        logic [W-1:0] ra, rb;

        bus.start = 1'b0;
        bus.f = '0;
        bus.a = '0;
        bus.b = '0;
        ym = '0; zm = 1'b1; him = '0; lom = '0; multim = 1'b0;

        #12;
        chk_reset_state("reset");
        @(negedge clk);
        reset_n = 1'b1;

        tv.push_back('{4'd0,  32'hF0F0_00FF, 32'h0FF0_FFFF, 32'h00F0_00FF, 1'b0});
        tv.push_back('{4'd6,  32'd5,         32'd5,         32'd0,         1'b1});
        tv.push_back('{4'd7,  32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0});
        tv.push_back('{4'd6,  32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0});
        tv.push_back('{4'd7,  32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         1'b1});
        tv.push_back('{4'd7,  32'hFFFF_FFFF, 32'd3,         32'd1,         1'b0});
        tv.push_back('{4'd1,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0});
        tv.push_back('{4'd2,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1});
        tv.push_back('{4'd2,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0});
        tv.push_back('{4'd3,  32'h1234,      32'h5678,      32'd0,         1'b1});
        tv.push_back('{4'd4,  32'd5,         32'd3,         32'd1,         1'b0});
        tv.push_back('{4'd5,  32'd0,         32'hFFFF_0000, 32'h0000_FFFF, 1'b0});
        tv.push_back('{4'd12, 32'd7,         32'd9,         32'd0,         1'b1});
        tv.push_back('{4'd1,  32'h0000_AAAA, 32'h0000_5555, 32'h0000_FFFF, 1'b0});
        tv.push_back('{4'd15, 32'd1,         32'd1,         32'd0,         1'b1});
        tv.push_back('{4'd1,  32'd1,         32'd2,         32'd3,         1'b0});
        tv.push_back('{4'd14, 32'd1,         32'd1,         32'd0,         1'b1});
        tv.push_back('{4'd13, 32'd4,         32'd4,         32'd0,         1'b1});

        foreach (tv[i]) begin
            issue(tv[i].f, tv[i].a, tv[i].b, lat, bc);
            chk($sformatf("vec%0d done", i), bus.done, 1'b1);
            chk($sformatf("vec%0d latency", i), lat, 0);
            chk($sformatf("vec%0d busy", i), bc, 0);
            chk($sformatf("vec%0d y", i), bus.y, tv[i].y);
            chk($sformatf("vec%0d zero", i), bus.zero, tv[i].z);
        end
        ym = tv[tv.size()-1].y;
        zm = tv[tv.size()-1].z;
        @(posedge clk);
        #1;
        chk("done pulse width", bus.done, 1'b0);

        run_op("mult -3*7", 4'd9, 32'hFFFF_FFFD, 32'd7);
        chk("mult hi const", bus.hi, 32'hFFFF_FFFF);
        chk("mult lo const", bus.lo, 32'hFFFF_FFEB);
        run_op("multu max^2", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mfhi", 4'd12, 32'd0, 32'd0);
        chk("mfhi const", bus.y, 32'hFFFF_FFFE);
        run_op("mflo", 4'd13, 32'd0, 32'd0);
        chk("mflo const", bus.y, 32'd1);

`ifdef SEQ_ALU_DIV_EN
        run_op("div -7/2", 4'd11, 32'hFFFF_FFF9, 32'd2);
        chk("div lo const", bus.lo, 32'hFFFF_FFFD);
        chk("div hi const", bus.hi, 32'hFFFF_FFFF);
        run_op("div minneg/-1", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div ovf lo const", bus.lo, 32'h8000_0000);
        chk("div ovf hi const", bus.hi, 32'd0);
        run_op("divu 9/0", 4'd10, 32'd9, 32'd0);
        chk("divu0 lo const", bus.lo, 32'hFFFF_FFFF);
        chk("divu0 hi const", bus.hi, 32'd9);
        run_op("div -9/0", 4'd11, 32'hFFFF_FFF7, 32'd0);
`else
        run_op("divu reserved", 4'd10, 32'd9, 32'd3);
        chk("divu reserved y", bus.y, 32'd0);
        run_op("div reserved", 4'd11, 32'hFFFF_FFF9, 32'd2);
`endif

        // Start pulse with a different op mid-MULT must be ignored.
        model_op(4'd9, 32'd100, 32'hFFFF_FFFB);
        @(negedge clk);
        bus.start = 1'b1; bus.f = 4'd9; bus.a = 32'd100; bus.b = 32'hFFFF_FFFB;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        for (int c = 1; c < W + 8; c++) begin
            if (c == 5) begin
                bus.start = 1'b1; bus.f = 4'd0; bus.a = '1; bus.b = '1;
            end
            if (c == 6) bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("ignored start done count", dones, 1);
        chk("ignored start hi", bus.hi, him);
        chk("ignored start lo", bus.lo, lom);
        chk("ignored start y", bus.y, ym);

        // Asynchronous reset in the middle of an iterative op.
        @(negedge clk);
        bus.start = 1'b1;
`ifdef SEQ_ALU_DIV_EN
        bus.f = 4'd11;
`else
        bus.f = 4'd9;
`endif
        bus.a = 32'd1000; bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_state("mid-op reset");
        ym = '0; zm = 1'b1; him = '0; lom = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int c = 0; c < W + 5; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("no done after reset", dones, 0);
        chk_reset_state("after reset idle");

        for (int i = 0; i < 40; i++) begin
            rf = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 5) == 0) rb = -rb;
            run_op($sformatf("rand%0d f=%0d", i, rf), rf, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the MIPS datapath, successor to the single-cycle combinational ALU. Executes the 3-bit logic/arithmetic op set with a registered result and adds iterative signed/unsigned multiply and divide writing HI/LO, under a start/busy/done handshake. Sits in the execute stage; the controller stalls on `busy`.

## Interface
- `WIDTH`, 32: operand/result width (≥ 4).
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `f`  in  4  op: `f[3]=0` → 0 AND, 1 OR, 2 ADD, 3 zero, 4 a+~b, 5 a|~b, 6 SUB, 7 SLT; `f[3]=1` → 8 MULTU, 9 MULT, 10 DIVU, 11 DIV, 12 MFHI, 13 MFLO, 14–15 reserved.
- `a`, `b`  in  WIDTH  operands; captured at accept.
- `y`  out  WIDTH  registered result.
- `zero`  out  1  registered, `y == 0`.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.
- `busy`  out  1  high from the cycle after accept until `done`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + `start`: `f[3]=0`, MFHI, MFLO, reserved → compute, load `y`/`zero`, assert `done` next cycle, stay IDLE. Reserved → `y=0`, `zero=1`, HI/LO unchanged.
- IDLE + `start` + mul op → MUL; div op → DIV. Operands are latched as magnitudes for signed ops, along with the result-sign flags.
- MUL: WIDTH shift-add iterations into a 2·WIDTH product register.
- DIV: WIDTH restoring-division iterations (remainder/quotient).
- After the last iteration → FIX: apply signs, write HI/LO, pulse `done` → IDLE. `y`/`zero` are not changed by mul/div.
- Sign rules:
  - Quotient negative iff operand signs differ.
  - Remainder takes the sign of `a`.
  - MULT product is negated iff operand signs differ.
- Divide by zero: `lo` = all ones, `hi` = `a` (unsigned and signed).
- Signed DIV of most-negative by −1: `lo` = most-negative, `hi` = 0.
- SLT: true signed compare, `y = {0…,a<b}`; correct even on subtract overflow.
- ADD/SUB wrap modulo 2^WIDTH. No overflow flag.
- `start` while `busy` is ignored. Operand and `f` changes during busy are ignored.

## Timing
- Accept edge = rising edge with IDLE && `start`.
- Single-cycle ops: `y`, `zero`, `done` valid in the cycle after the accept edge; `busy` stays 0.
- Mul/div: `busy`=1 for WIDTH+1 cycles after accept; `done` follows the FIX edge. Accept→done latency is WIDTH+1 cycles.
- Back-to-back: a new `start` is accepted on the same edge that `done` is presented, since the FSM is in IDLE.
- MFHI/MFLO issued immediately after `done` of a mul/div read the new HI/LO.
- Reset (any time, including mid-operation):
  - `y`=0, `zero`=1, `hi`=`lo`=0, `busy`=0, `done`=0, state IDLE.
  - An in-flight result is discarded.

## Configuration
- `SEQ_ALU_DIV_EN` defined: DIV/DIVU implemented as above.
- Undefined: no divider hardware. DIV/DIVU behave as reserved ops: 1-cycle `done`, `y`=0, HI/LO unchanged. DIV state unreachable.

## Structure
- Package `alu_pkg`: `alu_op_e` enum for the 4-bit `f` codes, `state_e` FSM enum, `ALU_OP_W = 4`.
- One sub-module: `seq_muldiv`, holding the iterative mul/div datapath, iteration counter and sign fix. It exposes `go`, `is_div`, `is_signed`, `fin`, `hi`, `lo`.
- The top holds the combinational op mux, the `y`/`zero` registers and the FSM.

## Test plan
All scenarios use WIDTH=32.
- Reset, then AND 0xF0F0_00FF & 0x0FF0_FFFF → `y`=0x00F0_00FF, `zero`=0, `done` one cycle after the accept edge. Repeat with SUB 5−5 → `y`=0, `zero`=1.
- SLT a=0x8000_0000, b=0x7FFF_FFFF → `y`=1. Same operands, SUB → `y`=0x0000_0001, wrap, no flag.
- MULT a=−3, b=7 → `busy` for 33 cycles; `done`; `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFEB. MULTU 0xFFFF_FFFF², then MFHI → `y`=0xFFFF_FFFE; MFLO → `y`=1.
- DIV a=−7, b=2 → `lo`=0xFFFF_FFFD (−3), `hi`=0xFFFF_FFFF (−1). DIV 0x8000_0000 / −1 → `lo`=0x8000_0000, `hi`=0. DIVU 9/0 → `lo`=0xFFFF_FFFF, `hi`=9.
- During MULT, pulse `start` with AND at cycle 5 → ignored; exactly one `done`. Assert `reset_n`=0 at cycle 10 of a DIV → all outputs at reset values; no `done`.
- Build without `SEQ_ALU_DIV_EN`: DIVU 9/3 → `done` after 1 cycle, `y`=0, HI/LO unchanged.
